// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
// ---------------
// APB3 initiator. A host-side agent hands over single read/write requests on a
// valid/ready channel, the block runs each one as an APB SETUP + ACCESS
// transfer (stretching ACCESS while PREADY is low) and returns the outcome on
// a valid/ready response channel. Only one transfer is in flight at a time.
// An optional wait-state limit aborts a transfer whose slave never answers,
// so a dead peripheral cannot hang the host.
//
// Parameters
//   AW       address width of req_addr / PADDR
//   TIMEOUT  ACCESS cycles with PREADY low before abort (0 = never abort)
//   TOW      wait counter width, 2**TOW must exceed TIMEOUT
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake
//   req_write, req_addr,
//   req_wdata                  request payload (sampled on accept only)
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata                  read data (0 for writes, DEADDEAD on abort)
//   rsp_err                    PSLVERR seen at completion, or abort
//   rsp_timeout                transfer aborted by the wait-state limit
//   PSEL, PENABLE, PWRITE,
//   PADDR, PWDATA              APB request outputs
//   PRDATA, PREADY, PSLVERR    APB completer inputs

module apb_master_ctrl #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 256,
  parameter int TOW     = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [31:0]   PWDATA,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // The abort fires in the ACCESS cycle whose wait count equals TIMEOUT-1,
  // i.e. on the TIMEOUT-th consecutive cycle with PREADY low.
  localparam logic           TO_EN_C      = (TIMEOUT != 32'sd0) ? 1'b1 : 1'b0;
  localparam logic [TOW-1:0] TO_LAST_C    = TOW'(TIMEOUT - 32'sd1);
  localparam logic [TOW-1:0] CNT_ONE_C    = {{(TOW-1){1'b0}}, 1'b1};
  localparam logic [31:0]    ABORT_DATA_C = 32'hDEAD_DEAD;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [TOW-1:0] wait_cnt_r;
  logic [TOW-1:0] wait_cnt_nxt_s;
  logic           req_ready_s;
  logic           accept_s;
  logic           done_s;
  logic           abort_s;

  logic [AW-1:0]  paddr_r;
  logic           pwrite_r;
  logic [31:0]    pwdata_r;
  logic           rsp_valid_r;
  logic [31:0]    rsp_rdata_r;
  logic           rsp_err_r;
  logic           rsp_timeout_r;

  // A pending response must drain (or drain this cycle) before a new accept.
  assign req_ready_s = (state_r == ST_IDLE) && (!rsp_valid_r || rsp_ready);

  // Next-state, wait counter and transfer-event decode.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = {TOW{1'b0}};
    accept_s       = 1'b0;
    done_s         = 1'b0;
    abort_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A late PREADY in the would-be abort cycle still completes normally.
        if (PREADY) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (TO_EN_C && (wait_cnt_r == TO_LAST_C)) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + CNT_ONE_C;
          state_nxt_s    = ST_ACCESS;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {TOW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // APB request fields: captured on accept and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr_r  <= {AW{1'b0}};
      pwrite_r <= 1'b0;
      pwdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      paddr_r  <= req_addr;
      pwrite_r <= req_write;
      pwdata_r <= req_write ? req_wdata : 32'h0000_0000;
    end else begin
      paddr_r  <= paddr_r;
      pwrite_r <= pwrite_r;
      pwdata_r <= pwdata_r;
    end
  end

  // Response register: loaded on completion/abort, held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 32'h0000_0000;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else if (done_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_rdata_r   <= pwrite_r ? 32'h0000_0000 : PRDATA;
      rsp_err_r     <= PSLVERR;
      rsp_timeout_r <= 1'b0;
    end else if (abort_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_rdata_r   <= ABORT_DATA_C;
      rsp_err_r     <= 1'b1;
      rsp_timeout_r <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= rsp_rdata_r;
      rsp_err_r     <= rsp_err_r;
      rsp_timeout_r <= rsp_timeout_r;
    end else begin
      rsp_valid_r   <= rsp_valid_r;
      rsp_rdata_r   <= rsp_rdata_r;
      rsp_err_r     <= rsp_err_r;
      rsp_timeout_r <= rsp_timeout_r;
    end
  end

  // PSEL/PENABLE are plain decodes of the state register, so glitch-free.
  assign PSEL        = (state_r != ST_IDLE);
  assign PENABLE     = (state_r == ST_ACCESS);
  assign PWRITE      = pwrite_r;
  assign PADDR       = paddr_r;
  assign PWDATA      = pwdata_r;
  assign req_ready   = req_ready_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule
